// File: rtl/fetch_issue_ctrl.sv
// fetch_issue_ctrl: front-end sequencing controller for the Tomasulo CPU.
// Drives IF_ID stall/flush, PC write-enable and PC source select.
//   - Holds fetch/decode when the DECODE instruction cannot issue (RS group full,
//     ROB full, or instruction memory not ready).
//   - On a CDB-resolved mispredict, redirects the PC and flushes IF_ID for a fixed
//     number of cycles.
//   - Parks the front end permanently on a decoded HALT (only reset exits).
// Ports:
//   clk, reset (async, active-low)
//   imem_ready, rs_full[N_RS], rs_sel[N_RS] (one-hot), rob_full, decode_valid,
//   halt_DECODE, cdb_redirect, redirect_pc[N_PC]          -- inputs
//   stall, flush, pc_we, pc_sel, pc_target[N_PC], issue_valid, state[2] -- outputs
// Optional feature: define STALL_PERF_EN to add saturating 16-bit counters
//   perf_stall_cnt / perf_flush_cnt.
module fetch_issue_ctrl #(
  parameter int unsigned N_PC         = 9,
  parameter int unsigned N_RS         = 3,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            imem_ready,
  input  logic [N_RS-1:0] rs_full,
  input  logic [N_RS-1:0] rs_sel,
  input  logic            rob_full,
  input  logic            decode_valid,
  input  logic            halt_DECODE,
  input  logic            cdb_redirect,
  input  logic [N_PC-1:0] redirect_pc,
  output logic            stall,
  output logic            flush,
  output logic            pc_we,
  output logic            pc_sel,
  output logic [N_PC-1:0] pc_target,
  output logic            issue_valid,
`ifdef STALL_PERF_EN
  output logic [15:0]     perf_stall_cnt,
  output logic [15:0]     perf_flush_cnt,
`endif
  output logic [1:0]      state
);

  localparam int unsigned CntW = $clog2(FLUSH_CYCLES) + 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StStall = 2'd1,
    StFlush = 2'd2,
    StHalt  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [N_PC-1:0]   tgt_q, tgt_d;
  logic              hazard;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StRun;
      cnt_q   <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    hazard = (decode_valid & (rob_full | (|(rs_full & rs_sel)))) | ~imem_ready;

    state_d     = state_q;
    cnt_d       = cnt_q;
    tgt_d       = tgt_q;
    stall       = 1'b0;
    flush       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 1'b0;
    issue_valid = 1'b0;

    unique case (state_q)
      StRun, StStall: begin
        stall       = hazard;
        pc_we       = ~hazard;
        issue_valid = decode_valid & ~hazard & ~halt_DECODE;
        if (decode_valid && halt_DECODE && !hazard) begin
          state_d = StHalt;
        end else if (hazard) begin
          state_d = StStall;
        end else begin
          state_d = StRun;
        end
      end
      StFlush: begin
        flush = 1'b1;
        if (cnt_q == '0) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StHalt: begin
        stall = 1'b1;
      end
      default: ;
    endcase

    // Mispredict beats everything except HALT; the PC takes redirect_pc directly
    // this cycle, pc_target only holds it for observation afterwards.
    if (cdb_redirect && state_q != StHalt) begin
      state_d     = StFlush;
      cnt_d       = CntLoad;
      tgt_d       = redirect_pc;
      flush       = 1'b1;
      stall       = 1'b0;
      pc_we       = 1'b1;
      pc_sel      = 1'b1;
      issue_valid = 1'b0;
    end

    // Outputs go quiet immediately while reset is held, not just at the next edge.
    if (!reset) begin
      stall       = 1'b0;
      flush       = 1'b0;
      pc_we       = 1'b0;
      pc_sel      = 1'b0;
      issue_valid = 1'b0;
    end
  end

  assign pc_target = tgt_q;
  assign state     = state_q;

`ifdef STALL_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall && state_q != StHalt && perf_stall_cnt != 16'hFFFF) begin
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
      end
      if (flush && perf_flush_cnt != 16'hFFFF) begin
        perf_flush_cnt <= perf_flush_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_issue_ctrl.sv
// Self-checking bench for fetch_issue_ctrl: directed scenarios followed by random
// stimulus, all compared against a behavioural model of the controller.
module tb_fetch_issue_ctrl;

  localparam int FC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       imem_ready;
  logic [2:0] rs_full;
  logic [2:0] rs_sel;
  logic       rob_full;
  logic       decode_valid;
  logic       halt_DECODE;
  logic       cdb_redirect;
  logic [8:0] redirect_pc;
  logic       stall, flush, pc_we, pc_sel, issue_valid;
  logic [8:0] pc_target;
  logic [1:0] state;
`ifdef STALL_PERF_EN
  logic [15:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Model: 0 run, 1 stall, 2 flush, 3 halt; m_left = flush bubbles still to come.
  int         m_state;
  int         m_left;
  logic [8:0] m_tgt;
  int         m_ps, m_pf;
  logic       e_stall, e_flush, e_we, e_sel, e_iv;

  fetch_issue_ctrl #(.N_PC(9), .N_RS(3), .FLUSH_CYCLES(FC)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_ready   (imem_ready),
    .rs_full      (rs_full),
    .rs_sel       (rs_sel),
    .rob_full     (rob_full),
    .decode_valid (decode_valid),
    .halt_DECODE  (halt_DECODE),
    .cdb_redirect (cdb_redirect),
    .redirect_pc  (redirect_pc),
    .stall        (stall),
    .flush        (flush),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .pc_target    (pc_target),
    .issue_valid  (issue_valid),
`ifdef STALL_PERF_EN
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt),
`endif
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_left  = 0;
    m_tgt   = '0;
    m_ps    = 0;
    m_pf    = 0;
  endtask

  task automatic set_idle();
    imem_ready = 1'b1; rs_full = '0; rs_sel = '0; rob_full = 1'b0;
    decode_valid = 1'b0; halt_DECODE = 1'b0; cdb_redirect = 1'b0; redirect_pc = '0;
  endtask

  // One clock: check combinational outputs mid-cycle, advance model at the edge,
  // then check registered state. Inputs must already be applied by the caller.
  task automatic cycle();
    logic blocked;
    #2;
    if (!reset) model_reset();
    blocked = (decode_valid && (rob_full || ((rs_full & rs_sel) != 3'b000))) || !imem_ready;
    {e_stall, e_flush, e_we, e_sel, e_iv} = '0;
    if (reset) begin
      if (cdb_redirect && m_state != 3) begin
        e_flush = 1; e_we = 1; e_sel = 1;
      end else if (m_state <= 1) begin
        e_stall = blocked; e_we = !blocked;
        e_iv = decode_valid && !blocked && !halt_DECODE;
      end else if (m_state == 2) begin
        e_flush = 1;
      end else begin
        e_stall = 1;
      end
    end
    chk("stall", stall, e_stall);
    chk("flush", flush, e_flush);
    chk("pc_we", pc_we, e_we);
    chk("pc_sel", pc_sel, e_sel);
    chk("issue_valid", issue_valid, e_iv);
    @(posedge clk);
    if (reset) begin
      if (e_stall && m_state != 3 && m_ps < 65535) m_ps++;
      if (e_flush && m_pf < 65535) m_pf++;
      if (cdb_redirect && m_state != 3) begin
        m_state = 2; m_left = FC; m_tgt = redirect_pc;
      end else if (m_state <= 1) begin
        if (decode_valid && halt_DECODE && !blocked) m_state = 3;
        else m_state = blocked ? 1 : 0;
      end else if (m_state == 2) begin
        m_left--;
        if (m_left == 0) m_state = 0;
      end
    end
    #1;
    chk("state", state, m_state);
    chk("pc_target", pc_target, m_tgt);
`ifdef STALL_PERF_EN
    chk("perf_stall_cnt", perf_stall_cnt, m_ps);
    chk("perf_flush_cnt", perf_flush_cnt, m_pf);
`endif
  endtask

  initial begin
    logic [2:0] pick;
    reset = 1'b0;
    set_idle();
    model_reset();
    cycle();
    chk("reset_state", state, 0);
    reset = 1'b1;

    // 1: async reset in the middle of a stall
    decode_valid = 1; rob_full = 1;
    cycle(); cycle();
    chk("t1_in_stall", state, 1);
    #2 reset = 1'b0;
    #1 chk("t1_async_state", state, 0);
    chk("t1_async_stall", stall, 0);
    chk("t1_async_we", pc_we, 0);
    cycle();
    reset = 1'b1; rob_full = 0;
    cycle();
    decode_valid = 0;
    cycle();

    // 2: RS group busy for 4 cycles, then issue
    decode_valid = 1; rs_sel = 3'b010; rs_full = 3'b010;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t2_stall", e_stall, 1);
    end
    rs_full = 3'b000;
    cycle();
    chk("t2_issue", issue_valid, 1);
    set_idle();

    // 3: mispredict redirect
    cdb_redirect = 1; redirect_pc = 9'h05A;
    cycle();
    cdb_redirect = 0; redirect_pc = 9'h1FF;
    cycle();
    chk("t3_target", pc_target, 9'h05A);
    cycle();
    chk("t3_run", state, 0);
    cycle();

    // 4: redirect beats hazard and halt; second redirect mid-flush reloads
    decode_valid = 1; rob_full = 1; halt_DECODE = 1;
    cdb_redirect = 1; redirect_pc = 9'h010;
    cycle();
    chk("t4_flush", state, 2);
    redirect_pc = 9'h020;
    cycle();
    chk("t4_target", pc_target, 9'h020);
    set_idle();
    cycle(); cycle(); cycle();
    chk("t4_run", state, 0);

    // 5: HALT is sticky, redirect ignored, reset exits
    decode_valid = 1; halt_DECODE = 1;
    cycle();
    chk("t5_halt", state, 3);
    set_idle();
    cdb_redirect = 1; redirect_pc = 9'h033;
    cycle();
    cdb_redirect = 0;
    cycle();
    reset = 0; cycle();
    reset = 1; cycle();
    chk("t5_exit", state, 0);

`ifdef STALL_PERF_EN
    // 6: perf counters and saturation
    reset = 0; cycle(); reset = 1;
    imem_ready = 0;
    cycle(); cycle(); cycle();
    imem_ready = 1; cdb_redirect = 1; redirect_pc = 9'h044;
    cycle();
    cdb_redirect = 0;
    cycle(); cycle(); cycle();
    chk("t6_stall_cnt", perf_stall_cnt, 3);
    chk("t6_flush_cnt", perf_flush_cnt, 3);
    imem_ready = 0;
    for (int i = 0; i < 70000; i++) cycle();
    chk("t6_saturate", perf_stall_cnt, 16'hFFFF);
    imem_ready = 1;
`endif

    // Random stimulus
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 39) != 0);
      imem_ready   = ($urandom_range(0, 5) != 0);
      pick         = 3'($urandom_range(0, 7));
      rs_sel       = (pick < 3) ? (3'b001 << pick) : (pick == 7 ? 3'($urandom) : 3'b000);
      rs_full      = 3'($urandom);
      rob_full     = ($urandom_range(0, 5) == 0);
      decode_valid = ($urandom_range(0, 3) != 0);
      halt_DECODE  = ($urandom_range(0, 24) == 0);
      cdb_redirect = ($urandom_range(0, 9) == 0);
      redirect_pc  = 9'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_issue_ctrl.md
Name: fetch_issue_ctrl

Overview:
Sequencing controller for the front end of the Tomasulo CPU: drives the IF_ID pipeline register's stall and flush, plus the PC write-enable and PC source select.
- Holds fetch/decode when the decoded instruction cannot issue: target reservation-station group full, ROB full, or instruction memory not ready.
- Performs a fixed-length flush and PC redirect on a CDB-resolved mispredict.
- Parks the front end on a decoded HALT.

Parameters:
N_PC, 9, PC width (matches the IF_ID PC field)
N_RS, 3, number of reservation-station groups (ALU, LD/ST, BR)
FLUSH_CYCLES, 2, cycles the FLUSH state holds IF_ID in bubble (>=1)

Ports:
clk  in  1  clock, rising-edge
reset  in  1  asynchronous, active-low reset
imem_ready  in  1  instruction memory returns valid instruction this cycle
rs_full  in  N_RS  per-group reservation station full flag
rs_sel  in  N_RS  one-hot group required by the instruction in DECODE (all-zero = needs none, e.g. NOP)
rob_full  in  1  reorder buffer has no free entry
decode_valid  in  1  DECODE holds a real (non-bubble) instruction
halt_DECODE  in  1  DECODE instruction is HALT
cdb_redirect  in  1  branch resolved on CDB as mispredicted (single-cycle pulse)
redirect_pc  in  N_PC  correct target, valid with cdb_redirect
stall  out  1  hold IF_ID
flush  out  1  load bubble (all-zero) into IF_ID
pc_we  out  1  PC register write enable
pc_sel  out  1  0 = PC+1, 1 = redirect target
pc_target  out  N_PC  registered redirect target
issue_valid  out  1  DECODE instruction dispatched this cycle
state  out  2  FSM state (debug)

Behaviour:
- States: RUN=0, STALL=1, FLUSH=2, HALT=3. Registers: state, flush counter cnt (width clog2(FLUSH_CYCLES)+1), pc_target.
- reset low, asynchronous: state=RUN, cnt=0, pc_target=0, and all registered outputs 0. First cycle after reset release is RUN.
- hazard = decode_valid & (rob_full | |(rs_full & rs_sel)) | ~imem_ready.
- Transition priority, every state except HALT, is cdb_redirect > halt > hazard:
  - cdb_redirect=1: next=FLUSH, cnt=FLUSH_CYCLES-1, pc_target<=redirect_pc. This also applies when the redirect arrives mid-FLUSH: the counter reloads and the newest target wins.
  - In RUN/STALL with decode_valid & halt_DECODE & ~hazard: next=HALT.
  - In RUN with hazard: next=STALL.
  - In STALL with ~hazard: next=RUN.
  - In FLUSH with cnt==0: next=RUN; otherwise cnt decrements.
  - HALT is sticky. Only reset exits it; cdb_redirect is ignored in HALT.
- Outputs, combinational from state and current inputs:
  - RUN/STALL: stall=hazard; flush=0; pc_we=~hazard; pc_sel=0; issue_valid=decode_valid & ~hazard & ~halt_DECODE.
  - Same-cycle cdb_redirect, any non-HALT state: flush=1, stall=0, pc_we=1, pc_sel=1. The PC takes redirect_pc directly this cycle (pass-through, pc_target is not used yet) and issue_valid=0.
  - FLUSH: flush=1, stall=0, pc_we=0, issue_valid=0.
  - HALT: stall=1, pc_we=0, flush=0, issue_valid=0.
- flush has priority over stall at IF_ID: stall and flush are never both 1.
- Redirect-to-first-issue latency: redirect cycle + FLUSH_CYCLES bubble cycles, then RUN.
- rs_sel with more than one bit set is illegal. The block still ORs across the selected bits.
- pc_target width is N_PC; no arithmetic; no wrap handling needed.

Optional Feature:
STALL_PERF_EN
- Defined: adds output perf_stall_cnt[15:0] and perf_flush_cnt[15:0].
  - perf_stall_cnt increments each cycle stall=1 and state!=HALT.
  - perf_flush_cnt increments each cycle flush=1.
  - Both saturate at 16'hFFFF and clear on reset.
- Not defined: ports and counters are absent. Core behaviour is identical.

Test Plan:
1. Reset low mid-STALL (rob_full=1) -> state=0, stall=0, pc_we=0 immediately (asynchronous); after release with imem_ready=1 and no hazards -> pc_we=1, issue_valid follows decode_valid.
2. decode_valid=1, rs_sel=3'b010, rs_full=3'b010 for 4 cycles then 0 -> stall=1 and pc_we=0 for exactly 4 cycles, state=STALL; issue_valid=1 on the 5th cycle.
3. cdb_redirect pulse with redirect_pc=9'h05A, FLUSH_CYCLES=2 -> that cycle pc_sel=1, pc_we=1, flush=1; next 2 cycles flush=1, state=2, pc_target=9'h05A; then state=RUN.
4. cdb_redirect (9'h010) in the same cycle as rob_full=1 and halt_DECODE=1 -> FLUSH entered, not STALL or HALT; a second redirect (9'h020) on FLUSH cycle 1 -> cnt reloads, pc_target=9'h020, 2 further flush cycles.
5. halt_DECODE=1, decode_valid=1, no hazard -> issue_valid=0, next state=HALT; a later cdb_redirect is ignored (stall stays 1); only reset exits.
6. With STALL_PERF_EN: 3 stall cycles plus one redirect with FLUSH_CYCLES=2 -> perf_stall_cnt=3, perf_flush_cnt=3; force 70000 stall cycles -> perf_stall_cnt=16'hFFFF.
